// File: rtl/apb_ucpd_bmc_tx.sv
// USB-PD BMC transmitter: preamble, 4b5b symbol serialisation from a one-entry buffer,
// and the end-of-frame hold sequence. All line activity is paced by the half-bit strobe.
module apb_ucpd_bmc_tx #(
  parameter int unsigned PREAMBLE_BITS = 64
) (
  input  logic       ic_clk,
  input  logic       ic_rst,
  input  logic       hbit_clk_red,
  input  logic       tx_start,
  input  logic       tx_abort,
  input  logic [4:0] sym_data,
  input  logic       sym_last,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic       ic_cc_out,
  output logic       cc_oen,
  output logic       bmc_en,
  output logic       tx_eop_cmplt,
  output logic       tx_underrun
);

  localparam int unsigned CntW = (PREAMBLE_BITS > 1) ? $clog2(PREAMBLE_BITS) : 1;

  typedef enum logic [1:0] {StIdle, StPreamble, StData, StHold} state_e;

  state_e            state_q, state_d;
  logic              h_q, h_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [4:0]        shift_q, shift_d;
  logic              shift_last_q, shift_last_d;
  logic [4:0]        buf_data_q, buf_data_d;
  logic              buf_last_q, buf_last_d;
  logic              buf_full_q, buf_full_d;
  logic [1:0]        hold_q, hold_d;
  logic              uflow_q, uflow_d;
  logic              cc_q, cc_d;
  logic              oen_q, oen_d;
  logic              eop_q, eop_d;
  logic              und_q, und_d;
  logic              handshake;
  logic              load_slot;

  assign sym_ready    = ((state_q == StPreamble) || (state_q == StData)) && !buf_full_q;
  assign ic_cc_out    = cc_q;
  assign cc_oen       = oen_q;
  assign bmc_en       = oen_q;
  assign tx_eop_cmplt = eop_q;
  assign tx_underrun  = und_q;

  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    shift_last_d = shift_last_q;
    buf_data_d   = buf_data_q;
    buf_last_d   = buf_last_q;
    buf_full_d   = buf_full_q;
    hold_d       = hold_q;
    uflow_d      = uflow_q;
    cc_d         = cc_q;
    oen_d        = oen_q;
    eop_d        = 1'b0;
    und_d        = 1'b0;
    handshake    = sym_valid && sym_ready;
    load_slot    = !h_q && (bit_idx_q == 3'd0);

    // A handshake only happens with the buffer empty, a load only with it full.
    if (handshake) begin
      buf_full_d = 1'b1;
      buf_data_d = sym_data;
      buf_last_d = sym_last;
    end

    if (state_q == StIdle) begin
      if (tx_start) begin
        state_d   = StPreamble;
        cnt_d     = '0;
        bit_idx_d = 3'd0;
        h_d       = 1'b0;
        hold_d    = 2'd0;
        uflow_d   = 1'b0;
        cc_d      = 1'b0;
        oen_d     = 1'b1;
      end
    end else if (tx_abort) begin
      state_d    = StIdle;
      buf_full_d = 1'b0;
      h_d        = 1'b0;
      cc_d       = 1'b0;
      oen_d      = 1'b0;
    end else if (hbit_clk_red) begin
      h_d = ~h_q;
      case (state_q)
        StPreamble: begin
          if (!h_q || cnt_q[0]) cc_d = ~cc_q;
          if (h_q) begin
            if (cnt_q == CntW'(PREAMBLE_BITS - 1)) begin
              state_d   = StData;
              bit_idx_d = 3'd0;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        StData: begin
          if (load_slot && !buf_full_q) begin
            und_d   = 1'b1;
            uflow_d = 1'b1;
            state_d = StHold;
            hold_d  = 2'd0;
          end else begin
            if (load_slot) begin
              shift_d      = buf_data_q;
              shift_last_d = buf_last_q;
              buf_full_d   = 1'b0;
            end
            // First half always toggles; second half toggles for a one.
            if (!h_q || shift_q[0]) cc_d = ~cc_q;
            if (h_q) begin
              shift_d = shift_q >> 1;
              if (bit_idx_q == 3'd4) begin
                bit_idx_d = 3'd0;
                if (shift_last_q) begin
                  state_d = StHold;
                  hold_d  = 2'd0;
                end
              end else begin
                bit_idx_d = bit_idx_q + 3'd1;
              end
            end
          end
        end
        StHold: begin
          hold_d = hold_q + 2'd1;
          case (hold_q)
            2'd0:    cc_d = ~cc_q;
            2'd1:    cc_d = 1'b0;
            default: begin
              oen_d   = 1'b0;
              eop_d   = ~uflow_q;
              state_d = StIdle;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ic_clk) begin
    if (ic_rst) begin
      state_q      <= StIdle;
      h_q          <= 1'b0;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 5'd0;
      shift_last_q <= 1'b0;
      buf_data_q   <= 5'd0;
      buf_last_q   <= 1'b0;
      buf_full_q   <= 1'b0;
      hold_q       <= 2'd0;
      uflow_q      <= 1'b0;
      cc_q         <= 1'b0;
      oen_q        <= 1'b0;
      eop_q        <= 1'b0;
      und_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      shift_last_q <= shift_last_d;
      buf_data_q   <= buf_data_d;
      buf_last_q   <= buf_last_d;
      buf_full_q   <= buf_full_d;
      hold_q       <= hold_d;
      uflow_q      <= uflow_d;
      cc_q         <= cc_d;
      oen_q        <= oen_d;
      eop_q        <= eop_d;
      und_q        <= und_d;
    end
  end

endmodule
